idct_mul_ctrl: RTL and testbench

Sequencer on the driving side of the IDCT approximate-multiplier wrapper. It generates the 3-bit phase code and the 9-bit `count0` beat counter that the wrapper consumes, and registers operand pairs from an upstream valid/ready stream onto the wrapper's A/B inputs. It retimes the wrapper's 32-bit product `P` back into a tagged result stream. One instance sits between the IDCT coefficient/sample buffer and each multiplier wrapper.

---
 rtl/idct_mul_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_idct_mul_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/idct_mul_ctrl.sv
// Driving-side sequencer for the IDCT approximate-multiplier wrapper: phase/beat
// generation, operand registers, product retiming into a tagged result stream.
module idct_mul_ctrl #(
  parameter int unsigned DATA_PATH_BITWIDTH = 24,
  parameter int unsigned B_BITWIDTH         = DATA_PATH_BITWIDTH - 11,
  parameter int unsigned MUL_LATENCY        = 4
) (
  input  logic                          clk,
  input  logic                          rstN,
  input  logic                          start,
  input  logic                          apx_mode,
  input  logic                          op_valid,
  output logic                          op_ready,
  input  logic [DATA_PATH_BITWIDTH-1:0] op_a,
  input  logic [B_BITWIDTH-1:0]         op_b,
  output logic [DATA_PATH_BITWIDTH-1:0] A_out,
  output logic [B_BITWIDTH-1:0]         B_out,
  output logic [2:0]                    state_out,
  output logic [8:0]                    count0,
  output logic                          rapx_out,
  input  logic [31:0]                   P_in,
  input  logic [2:0]                    state_echo,
  output logic                          res_valid,
  output logic [31:0]                   res_data,
  output logic                          res_col,
  output logic [5:0]                    res_idx,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    LOAD  = 3'b001,
    ROW   = 3'b010,
    COL   = 3'b011,
    DRAIN = 3'b100
  } phase_t;

  typedef struct packed {
    logic       v;
    logic       col;
    logic [5:0] idx;
  } tag_t;

  phase_t                        state_q, state_d;
  logic [2:0]                    state_d1_q;
  logic [8:0]                    count0_q, count0_d;
  logic                          rapx_q, rapx_d;
  logic                          done_q, done_d;
  logic                          err_q;
  logic [DATA_PATH_BITWIDTH-1:0] a_q;
  logic [B_BITWIDTH-1:0]         b_q;
  tag_t                          tag_q [MUL_LATENCY];
  tag_t                          tag_in;
  logic                          res_valid_q;
  logic [31:0]                   res_data_q;
  logic                          res_col_q;
  logic [5:0]                    res_idx_q;
  logic                          fire;
  logic                          beat_last;
  logic                          pipe_busy;
  logic                          busy_c;

  assign beat_last = (count0_q == 9'd63);
  assign op_ready  = ((state_q == LOAD) && beat_last) || (state_q == ROW) || (state_q == COL);
  assign fire      = op_valid & op_ready;
  assign busy_c    = (state_q != IDLE);

  // The LOAD-exit fire is row beat 0 even though count0 reads 63 at that point.
  always_comb begin
    tag_in     = '0;
    tag_in.v   = fire;
    tag_in.col = (state_q == COL);
    tag_in.idx = (state_q == LOAD) ? 6'd0 : count0_q[5:0];
  end

  always_comb begin
    pipe_busy = 1'b0;
    for (int unsigned i = 0; i < MUL_LATENCY; i++) begin
      pipe_busy = pipe_busy | tag_q[i].v;
    end
  end

  always_comb begin
    state_d  = state_q;
    count0_d = count0_q;
    rapx_d   = rapx_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !done_q) begin
          state_d  = LOAD;
          count0_d = '0;
          rapx_d   = apx_mode;
        end
      end
      LOAD: begin
        if (!beat_last) begin
          count0_d = count0_q + 9'd1;
        end else if (fire) begin
          count0_d = 9'd1;
          state_d  = ROW;
        end
      end
      ROW: begin
        if (fire) begin
          if (beat_last) begin
            count0_d = '0;
            state_d  = COL;
          end else begin
            count0_d = count0_q + 9'd1;
          end
        end
      end
      COL: begin
        if (fire) begin
          if (beat_last) begin
            count0_d = '0;
            state_d  = DRAIN;
          end else begin
            count0_d = count0_q + 9'd1;
          end
        end
      end
      DRAIN: begin
        if (!pipe_busy) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= IDLE;
      state_d1_q <= '0;
      count0_q   <= '0;
      rapx_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      state_d1_q <= state_q;
      count0_q   <= count0_d;
      rapx_q     <= rapx_d;
      done_q     <= done_d;
      err_q      <= err_q | (busy_c && (state_echo != state_d1_q));
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      a_q <= '0;
      b_q <= '0;
    end else if (fire) begin
      a_q <= op_a;
      b_q <= op_b;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int unsigned i = 0; i < MUL_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_col_q   <= 1'b0;
      res_idx_q   <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      res_valid_q <= tag_q[MUL_LATENCY-1].v;
      if (tag_q[MUL_LATENCY-1].v) begin
        res_data_q <= P_in;
        res_col_q  <= tag_q[MUL_LATENCY-1].col;
        res_idx_q  <= tag_q[MUL_LATENCY-1].idx;
      end
    end
  end

  assign A_out     = a_q;
  assign B_out     = b_q;
  assign state_out = state_q;
  assign count0    = count0_q;
  assign rapx_out  = rapx_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_col   = res_col_q;
  assign res_idx   = res_idx_q;
  assign busy      = busy_c;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_idct_mul_ctrl.sv
// Bench for idct_mul_ctrl: behavioural block model (beat counting and a result
// scoreboard) plus a small wrapper model supplying P_in and state_echo.
module tb_idct_mul_ctrl;

  localparam int DW  = 24;
  localparam int BW  = 13;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rstN;
  logic          start, apx_mode, op_valid, op_ready;
  logic [DW-1:0] op_a, A_out;
  logic [BW-1:0] op_b, B_out;
  logic [2:0]    state_out, state_echo;
  logic [8:0]    count0;
  logic          rapx_out;
  logic [31:0]   P_in;
  logic          res_valid, res_col, busy, done, err;
  logic [31:0]   res_data;
  logic [5:0]    res_idx;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit err_exp = 1'b0;
  logic glitch = 1'b0;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        col;
    logic [5:0]  idx;
  } exp_t;

  always #5 clk = ~clk;

  idct_mul_ctrl #(
    .DATA_PATH_BITWIDTH(DW),
    .B_BITWIDTH(BW),
    .MUL_LATENCY(LAT)
  ) dut (
    .clk(clk), .rstN(rstN), .start(start), .apx_mode(apx_mode),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .A_out(A_out), .B_out(B_out), .state_out(state_out), .count0(count0),
    .rapx_out(rapx_out), .P_in(P_in), .state_echo(state_echo),
    .res_valid(res_valid), .res_data(res_data), .res_col(res_col),
    .res_idx(res_idx), .busy(busy), .done(done), .err(err)
  );

  // Wrapper model: product valid LAT edges after the operand fire; state echoed one cycle late.
  logic [31:0] p1, p2, p3;
  logic [2:0]  echo_q;
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      p1 <= '0; p2 <= '0; p3 <= '0; echo_q <= '0;
    end else begin
      p1 <= {8'd0, A_out} * {19'd0, B_out};
      p2 <= p1;
      p3 <= p2;
      echo_q <= state_out;
    end
  end
  assign P_in       = p3;
  assign state_echo = glitch ? 3'b111 : echo_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic chk_reset_values(input string pfx);
    chk({pfx, "_op_ready"},  32'(op_ready),  32'd0);
    chk({pfx, "_busy"},      32'(busy),      32'd0);
    chk({pfx, "_done"},      32'(done),      32'd0);
    chk({pfx, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({pfx, "_err"},       32'(err),       32'd0);
    chk({pfx, "_rapx"},      32'(rapx_out),  32'd0);
    chk({pfx, "_state"},     32'(state_out), 32'd0);
    chk({pfx, "_count0"},    32'(count0),    32'd0);
    chk({pfx, "_A_out"},     32'(A_out),     32'd0);
    chk({pfx, "_B_out"},     32'(B_out),     32'd0);
    chk({pfx, "_res_data"},  res_data,       32'd0);
    chk({pfx, "_res_idx"},   32'(res_idx),   32'd0);
    chk({pfx, "_res_col"},   32'(res_col),   32'd0);
  endtask

  // One block: beat k (0..127) is row beat k or col beat k-64; LOAD lasts 64 cycles.
  task automatic run_block(input bit directed, input int load_stall, input int gap_beat,
                           input int gap_len, input int rnd_pct, input int glitch_beat,
                           input int abort_beat, input bit start_in_done);
    exp_t        q[$];
    exp_t        e;
    int          ncyc, nfired, stalls, gaps, done_due, guard, exp_state, exp_cnt;
    bit          fin, fire, v, exp_ready, exp_rapx, was_glitch;
    logic [23:0] a;
    logic [12:0] b;
    logic [63:0] prod;

    exp_rapx = 1'($urandom);
    apx_mode = exp_rapx;
    start    = 1'b1;
    step();
    start = 1'b0;
    ncyc = 0; nfired = 0; stalls = 0; gaps = 0; done_due = -1; guard = 0;
    fin = 1'b0; was_glitch = 1'b0;

    while (!fin && guard < 1000) begin
      guard++;
      if (nfired == 0) begin
        exp_state = 1; exp_cnt = (ncyc < 63) ? ncyc : 63;
      end else if (nfired < 64) begin
        exp_state = 2; exp_cnt = nfired;
      end else if (nfired < 128) begin
        exp_state = 3; exp_cnt = nfired - 64;
      end else begin
        exp_state = 4; exp_cnt = 0;
      end
      exp_ready = (nfired < 128) && (ncyc >= 63);
      chk("state",    32'(state_out), 32'(exp_state));
      chk("count0",   32'(count0),    32'(exp_cnt));
      chk("op_ready", 32'(op_ready),  32'(exp_ready));
      chk("busy",     32'(busy),      32'd1);
      chk("rapx",     32'(rapx_out),  32'(exp_rapx));

      if (abort_beat >= 0 && nfired == abort_beat) begin
        rstN = 1'b0;
        #1;
        err_exp = 1'b0;
        chk_reset_values("abort");
        repeat (3) begin
          step();
          chk("abort_res_valid", 32'(res_valid), 32'd0);
          chk("abort_done",      32'(done),      32'd0);
          chk("abort_busy",      32'(busy),      32'd0);
        end
        rstN = 1'b1;
        op_valid = 1'b0;
        step();
        chk("abort_idle", 32'(state_out), 32'd0);
        return;
      end

      v = 1'b1;
      if (nfired == 0 && exp_ready && stalls < load_stall) begin
        v = 1'b0; stalls++;
      end
      if (nfired == gap_beat && exp_ready && gaps < gap_len) begin
        v = 1'b0; gaps++;
      end
      if (rnd_pct > 0 && $urandom_range(99, 0) < rnd_pct) v = 1'b0;
      if (directed) begin
        a = 24'(nfired + 1); b = 13'd2;
      end else begin
        a = 24'($urandom); b = 13'($urandom);
      end
      op_valid = v; op_a = a; op_b = b;
      apx_mode = 1'($urandom);
      start    = (nfired == 30);
      glitch   = (nfired == glitch_beat) && !was_glitch;
      if (glitch) begin
        was_glitch = 1'b1;
        err_exp    = 1'b1;
      end
      fire = v && exp_ready;
      if (fire) begin
        prod   = {40'd0, a} * {51'd0, b};
        e.due  = cyc + 1 + LAT;
        e.data = prod[31:0];
        e.col  = (nfired >= 64);
        e.idx  = 6'(nfired % 64);
        q.push_back(e);
      end

      step();
      start  = 1'b0;
      glitch = 1'b0;
      ncyc++;
      if (fire) begin
        chk("A_out", 32'(A_out), 32'(a));
        chk("B_out", 32'(B_out), 32'(b));
        nfired++;
        if (nfired == 128) done_due = cyc + LAT + 1;
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        chk("res_valid", 32'(res_valid), 32'd1);
        chk("res_data",  res_data,       q[0].data);
        chk("res_col",   32'(res_col),   32'(q[0].col));
        chk("res_idx",   32'(res_idx),   32'(q[0].idx));
        void'(q.pop_front());
      end else begin
        chk("res_idle", 32'(res_valid), 32'd0);
      end
      chk("done", 32'(done), 32'(cyc == done_due));
      chk("err",  32'(err),  32'(err_exp));
      if (cyc == done_due) fin = 1'b1;
    end

    chk("done_seen",     32'(fin),       32'd1);
    chk("end_busy",      32'(busy),      32'd0);
    chk("end_state",     32'(state_out), 32'd0);
    chk("end_err",       32'(err),       32'(err_exp));
    chk("end_pending",   32'(q.size()),  32'd0);
    op_valid = 1'b0;
    start    = start_in_done;
    step();
    start = 1'b0;
    chk("post_done",  32'(done),      32'd0);
    chk("post_busy",  32'(busy),      32'd0);
    chk("post_state", 32'(state_out), 32'd0);
  endtask

  initial begin
    rstN = 1'b0; start = 1'b0; apx_mode = 1'b0; op_valid = 1'b0;
    op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_values("reset");
    rstN = 1'b1;
    step();
    chk("idle_state", 32'(state_out), 32'd0);

    // Directed operands k+1 / 2, no bubbles.
    run_block(1'b1, 0, -1, 0, 0, -1, -1, 1'b0);
    // Three-cycle bubble at row beat 10, random operands.
    run_block(1'b0, 0, 10, 3, 0, -1, -1, 1'b0);
    // op_valid low for five cycles at LOAD count0 63.
    run_block(1'b0, 5, -1, 0, 0, -1, -1, 1'b0);
    // Echo glitch mid-ROW, start pulsed in the done cycle.
    run_block(1'b0, 0, -1, 0, 0, 20, -1, 1'b1);
    // Reset asserted at column beat 20.
    run_block(1'b0, 0, -1, 0, 0, -1, 84, 1'b0);
    // Clean block after reset with random bubbles.
    run_block(1'b0, 2, 40, 2, 25, -1, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
